// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 UART receiver with 2-FF synchroniser and 3-sample mid-bit majority vote
module uart_receiver #(
  parameter int SYS_PERIOD = 100_000_000,
  parameter int BPS        = 115_200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rxd,
  output logic       receive_done,
  output logic [7:0] data_receive,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int BIT_PERIOD = SYS_PERIOD / BPS;
  localparam int HALF_BIT   = BIT_PERIOD / 2;
  localparam int CNT_W      = $clog2(BIT_PERIOD);

  localparam logic [CNT_W-1:0] CNT_S0   = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_S1   = CNT_W'(HALF_BIT);
  localparam logic [CNT_W-1:0] CNT_DEC  = CNT_W'(HALF_BIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_PERIOD - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             rx_meta;
  logic             rx_sync;
  logic             rx_prev;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic             samp0;
  logic             samp1;
  logic [7:0]       shreg;
  logic [7:0]       data_q;
  logic             start_edge;
  logic             at_s0;
  logic             at_s1;
  logic             at_dec;
  logic             at_wrap;
  logic             vote;
  logic             done_now;
  logic             err_now;
  logic             shift_en;

  // Flops reset high so a line held low across reset release looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rxd;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign start_edge = rx_prev & ~rx_sync;
  assign at_s0      = (cnt == CNT_S0);
  assign at_s1      = (cnt == CNT_S1);
  assign at_dec     = (cnt == CNT_DEC);
  assign at_wrap    = (cnt == CNT_LAST);
  assign vote       = (samp0 & samp1) | (samp0 & rx_sync) | (samp1 & rx_sync);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (start_edge) state_next = START;
      START: begin
        if (at_dec && vote) state_next = IDLE;
        else if (at_wrap)   state_next = DATA;
      end
      DATA:      if (at_wrap && bit_idx == 3'd7) state_next = STOP;
      STOP:      if (at_dec) state_next = vote ? IDLE : WAIT_IDLE;
      WAIT_IDLE: if (rx_sync) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Strobes fire in the decision cycle itself; data_receive bypasses to the fresh byte then.
  always_comb begin
    done_now     = (state == STOP) && at_dec && vote;
    err_now      = (state == STOP) && at_dec && !vote;
    shift_en     = (state == DATA) && at_dec;
    receive_done = done_now;
    frame_err    = err_now;
    data_receive = done_now ? shreg : data_q;
    rx_busy      = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      bit_idx <= 3'd0;
      samp0   <= 1'b1;
      samp1   <= 1'b1;
      shreg   <= 8'h00;
      data_q  <= 8'h00;
    end else begin
      if (state == IDLE || state == WAIT_IDLE ||
          state_next == IDLE || state_next == WAIT_IDLE) begin
        cnt <= '0;
      end else if (at_wrap) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end

      if (state != DATA) begin
        bit_idx <= 3'd0;
      end else if (at_wrap) begin
        bit_idx <= bit_idx + 3'd1;
      end

      if (at_s0) samp0 <= rx_sync;
      if (at_s1) samp1 <= rx_sync;
      if (shift_en) shreg <= {vote, shreg[7:1]};
      if (done_now) data_q <= shreg;
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - randomized and directed checks of uart_receiver against a frame-level scoreboard
module tb_uart_receiver;

  localparam int BP   = 868;
  localparam int HALF = 434;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       uart_rxd = 1'b1;
  logic       receive_done;
  logic [7:0] data_receive;
  logic       frame_err;
  logic       rx_busy;

  uart_receiver dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .uart_rxd     (uart_rxd),
    .receive_done (receive_done),
    .data_receive (data_receive),
    .frame_err    (frame_err),
    .rx_busy      (rx_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         kind;
    logic [7:0] data;
    int         at;
  } exp_t;

  exp_t       q[$];
  int         tests = 0;
  int         fails = 0;
  logic [7:0] model_last = 8'h00;
  int         done_cnt = 0;
  int         last_done_cyc = -1;
  int         last_err_cyc = -1;

  // Expected strobe for a frame whose start bit hits the pin in cycle p:
  // 2 synchroniser cycles, then 9 bit times, half a bit and 2 to the stop decision.
  always @(negedge clk) begin : cmp
    bit ed;
    bit ee;
    if (!rst_n) begin
      model_last = 8'h00;
      q.delete();
    end
    while (q.size() > 0 && q[0].at < cyc) begin
      tests++;
      fails++;
      $display("FAIL missed_strobe: kind %0d expected at cycle %0d, no strobe observed (now %0d)",
               q[0].kind, q[0].at, cyc);
      void'(q.pop_front());
    end
    ed = (q.size() > 0) && (q[0].at == cyc) && (q[0].kind == 1);
    ee = (q.size() > 0) && (q[0].at == cyc) && (q[0].kind == 2);
    tests++;
    if (receive_done !== ed) begin
      fails++;
      $display("FAIL receive_done @%0d: got %b, expected %b", cyc, receive_done, ed);
    end
    tests++;
    if (frame_err !== ee) begin
      fails++;
      $display("FAIL frame_err @%0d: got %b, expected %b", cyc, frame_err, ee);
    end
    if (ed) model_last = q[0].data;
    if (q.size() > 0 && q[0].at == cyc) begin
      tests++;
      if (rx_busy !== 1'b1) begin
        fails++;
        $display("FAIL busy_at_strobe @%0d: got %b, expected 1", cyc, rx_busy);
      end
      void'(q.pop_front());
    end
    tests++;
    if (data_receive !== model_last) begin
      fails++;
      $display("FAIL data_receive @%0d: got %02h, expected %02h", cyc, data_receive, model_last);
    end
    if (receive_done) begin
      done_cnt++;
      last_done_cyc = cyc;
    end
    if (frame_err) last_err_cyc = cyc;
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Drives ncyc cycles of a 10-bit frame; g1/g2 invert the pin for one cycle at that offset.
  task automatic send(input logic [7:0] d, input logic stop, input int ncyc,
                      input int g1, input int g2, input int kind, output int p);
    logic [9:0] fr;
    fr = {stop, d, 1'b0};
    @(posedge clk);
    #1;
    p = cyc;
    if (kind != 0) q.push_back('{kind, d, p + 9 * BP + HALF + 4});
    for (int j = 0; j < ncyc; j++) begin
      if (j > 0) begin
        @(posedge clk);
        #1;
      end
      uart_rxd = fr[j / BP] ^ ((j == g1) || (j == g2));
    end
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    int qc;
    int dc;
    logic [7:0] d;
    int rb;
    int g;

    repeat (4) @(posedge clk);
    @(negedge clk);
    check("reset_done", int'(receive_done), 0);
    check("reset_err", int'(frame_err), 0);
    check("reset_busy", int'(rx_busy), 0);
    check("reset_data", int'(data_receive), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);

    // 1: plain 0xA5 with exact latency
    send(8'hA5, 1'b1, 10 * BP, -1, -1, 1, p);
    check("t1_data", int'(data_receive), 8'hA5);
    check("t1_latency", last_done_cyc - p, 8250);
    check("t1_done_count", done_cnt, 1);

    // 2: 200-cycle false start
    repeat (50) @(posedge clk);
    #1 p = cyc;
    uart_rxd = 1'b0;
    repeat (200) begin
      @(posedge clk);
      #1;
    end
    uart_rxd = 1'b1;
    wait_cyc(p + 4 + HALF);
    check("t2_busy_at_decision", int'(rx_busy), 1);
    wait_cyc(p + 5 + HALF);
    check("t2_busy_after_decision", int'(rx_busy), 0);
    check("t2_no_done", done_cnt, 1);
    check("t2_no_err", last_err_cyc, -1);

    // 3: stop bit low, line stuck low
    repeat (30) @(posedge clk);
    send(8'h3C, 1'b0, 10 * BP, -1, -1, 2, p);
    check("t3_err_latency", last_err_cyc - p, 8250);
    repeat (2000) @(posedge clk);
    #1 qc = cyc;
    check("t3_busy_held", int'(rx_busy), 1);
    uart_rxd = 1'b1;
    wait_cyc(qc + 2);
    check("t3_busy_before_idle", int'(rx_busy), 1);
    wait_cyc(qc + 3);
    check("t3_busy_idle", int'(rx_busy), 0);
    check("t3_data_kept", int'(data_receive), 8'hA5);

    // 4: 0x08 with single-cycle glitches at the bit-3 and bit-2 mid samples
    repeat (30) @(posedge clk);
    send(8'h08, 1'b1, 10 * BP, 4 * BP + HALF + 1, 3 * BP + HALF + 1, 1, p);
    check("t4_data", int'(data_receive), 8'h08);

    // 5: back-to-back 0x00, 0xFF
    repeat (30) @(posedge clk);
    dc = done_cnt;
    send(8'h00, 1'b1, 10 * BP, -1, -1, 1, p);
    check("t5_first", int'(data_receive), 8'h00);
    send(8'hFF, 1'b1, 10 * BP, -1, -1, 1, p);
    check("t5_second", int'(data_receive), 8'hFF);
    check("t5_done_count", done_cnt - dc, 2);

    // 6: reset during bit 4 of 0x5A, then a clean 0x5A
    repeat (30) @(posedge clk);
    dc = done_cnt;
    send(8'h5A, 1'b1, 5 * BP + HALF, -1, -1, 0, p);
    @(posedge clk);
    #1 rst_n = 1'b0;
    uart_rxd = 1'b1;
    #1;
    check("t6_rst_data", int'(data_receive), 0);
    check("t6_rst_busy", int'(rx_busy), 0);
    check("t6_rst_done", int'(receive_done), 0);
    check("t6_rst_err", int'(frame_err), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    check("t6_no_partial_strobe", done_cnt - dc, 0);
    send(8'h5A, 1'b1, 10 * BP, -1, -1, 1, p);
    check("t6_data", int'(data_receive), 8'h5A);

    // random bytes, gaps and a one-cycle glitch on one sample of a random bit
    for (int r = 0; r < 2; r++) begin
      repeat ($urandom_range(1, 60)) @(posedge clk);
      d  = 8'($urandom);
      rb = int'($urandom_range(0, 7));
      g  = (rb + 1) * BP + HALF + int'($urandom_range(0, 2));
      send(d, 1'b1, 10 * BP, g, -1, 1, p);
      check("rand_data", int'(data_receive), int'(d));
    end

    repeat (50) @(posedge clk);
    check("scoreboard_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
